// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size, FSM state,
// latched request control fields and the alignment check.
package lsu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANE_W = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR,
    RESP
  } state_e;

  typedef struct packed {
    logic  we;
    size_e size;
    logic  uns;
  } req_ctl_t;

  // Size 11, odd half, or non-word-aligned word.
  function automatic logic misaligned(input logic [1:0] size, input logic [LANE_W-1:0] lo);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lo[0];
      2'b10:   misaligned = (lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response and memory-side bus of the LSU.
// master: the core and memory side; slave: the LSU.
interface lsu_if #(
  parameter int unsigned ADDR_WIDTH = 4
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic                  memRead;
  logic                  memWrite;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_data_in;
  logic [31:0]           mem_data_out;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err, memRead, memWrite, mem_address, mem_data_in
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err, memRead, memWrite, mem_address, mem_data_in
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends a byte/half from a
// memory word for loads, and merges store data into a word for RMW.
//   size, uns, lane : latched access size, zero-extend flag, addr[1:0]
//   rword           : word read from memory
//   wdata           : right-aligned store data
//   load_data       : extended load result
//   merged          : rword with addressed lanes replaced by wdata
module lsu_align
  import lsu_pkg::*;
(
  input  size_e              size,
  input  logic               uns,
  input  logic [LANE_W-1:0]  lane,
  input  logic [WORD_W-1:0]  rword,
  input  logic [WORD_W-1:0]  wdata,
  output logic [WORD_W-1:0]  load_data,
  output logic [WORD_W-1:0]  merged
);
  logic [4:0]        bsh;
  logic [4:0]        hsh;
  logic [7:0]        b;
  logic [15:0]       h;
  logic [WORD_W-1:0] mask;
  logic [WORD_W-1:0] ins;

  always_comb begin
    bsh       = {lane, 3'b000};
    hsh       = {lane[1], 4'b0000};
    b         = 8'(rword >> bsh);
    h         = 16'(rword >> hsh);
    load_data = rword;
    mask      = '1;
    ins       = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = uns ? WORD_W'(b) : {{24{b[7]}}, b};
        mask      = 32'h0000_00FF << bsh;
        ins       = WORD_W'(wdata[7:0]) << bsh;
      end
      SZ_HALF: begin
        load_data = uns ? WORD_W'(h) : {{16{h[15]}}, h};
        mask      = 32'h0000_FFFF << hsh;
        ins       = WORD_W'(wdata[15:0]) << hsh;
      end
      default: ;
    endcase
    merged = (rword & ~mask) | (ins & mask);
  end
endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one core request at a time, performs the
// memory access (read, write, or read-modify-write for sub-word
// stores) and returns a one-cycle response pulse.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request/response and memory ports (lsu_if.slave)
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);
  localparam int unsigned BA_W = ADDR_WIDTH + 2;
  localparam int unsigned W    = WORD_WIDTH;

  state_e          state_q, state_d;
  req_ctl_t        ctl_q;
  logic [BA_W-1:0] addr_q;
  logic [W-1:0]    wdata_q;
  logic            latch;

  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic [W-1:0]    mem_data_in_q, mem_data_in_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic [W-1:0]    resp_rdata_q, resp_rdata_d;

  logic [W-1:0]    load_data;
  logic [W-1:0]    merged;

  lsu_align u_align (
    .size      (ctl_q.size),
    .uns       (ctl_q.uns),
    .lane      (addr_q[1:0]),
    .rword     (bus.mem_data_out),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // Next state plus the registered strobe/response values for the next cycle.
  always_comb begin
    state_d       = state_q;
    latch         = 1'b0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_data_in_d = '0;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    resp_rdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          latch = 1'b1;
          if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!bus.req_we || (bus.req_size != SZ_WORD)) begin
            // Loads and sub-word stores both start with a read.
            state_d    = RD_REQ;
            mem_read_d = 1'b1;
          end else begin
            state_d       = WR;
            mem_write_d   = 1'b1;
            mem_data_in_d = bus.req_wdata;
          end
        end
      end
      RD_REQ:  state_d = RD_DATA;
      RD_DATA: begin
        if (ctl_q.we) begin
          state_d       = WR;
          mem_write_d   = 1'b1;
          mem_data_in_d = merged;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data;
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ctl_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_data_in_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_data_in_q <= mem_data_in_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      resp_rdata_q  <= resp_rdata_d;
      if (latch) begin
        ctl_q   <= '{we: bus.req_we, size: size_e'(bus.req_size), uns: bus.req_unsigned};
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
    end
  end

  assign bus.req_ready   = (state_q == IDLE) && !rst;
  assign bus.memRead     = mem_read_q;
  assign bus.memWrite    = mem_write_q;
  assign bus.mem_address = addr_q[BA_W-1:2];
  assign bus.mem_data_in = mem_data_in_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.resp_rdata  = resp_rdata_q;
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized
// traffic against a word-array reference model.
module tb_lsu;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst;
  lsu_if #(.ADDR_WIDTH(AW)) bus ();
  lsu #(.ADDR_WIDTH(AW), .WORD_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem    [16];
  logic [31:0] refmem [16];
  logic        bd_we   = 1'b0;
  logic [3:0]  bd_idx  = '0;
  logic [31:0] bd_data = '0;

  // Memory model: read data appears the cycle after memRead and holds.
  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    if (bus.memWrite) mem[bus.mem_address] <= bus.mem_data_in;
    if (bus.memRead) bus.mem_data_out <= mem[bus.mem_address];
  end

  // Every-cycle protocol checks.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      n_checks++;
      if (bus.memRead && bus.memWrite) begin
        n_fail++;
        $display("FAIL strobe_overlap: memRead=%b memWrite=%b required not both 1", bus.memRead, bus.memWrite);
      end
      n_checks++;
      if (!bus.memWrite && bus.mem_data_in !== 32'h0) begin
        n_fail++;
        $display("FAIL data_in_idle: got %h required 0", bus.mem_data_in);
      end
    end
  end

  function automatic logic ref_err(input logic [1:0] size, input logic [5:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                           input logic uns, input logic [5:0] addr);
    longint unsigned v;
    int unsigned sh;
    v = 0;
    if (size == 2'd0) begin
      sh = 8 * (addr % 4);
      v  = (longint'(word) >> sh) % 256;
      if (!uns && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (size == 2'd1) begin
      sh = 16 * ((addr % 4) / 2);
      v  = (longint'(word) >> sh) % 65536;
      if (!uns && v >= 32768) v = v + 64'hFFFF_0000;
    end else begin
      v = longint'(word);
    end
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] size,
                                            input logic [5:0] addr, input logic [31:0] wdata);
    longint unsigned o, lane_old, lane_new;
    int unsigned sh, m;
    o = longint'(old);
    if (size == 2'd2) return wdata;
    if (size == 2'd0) begin
      sh = 8 * (addr % 4);
      m  = 256;
    end else begin
      sh = 16 * ((addr % 4) / 2);
      m  = 65536;
    end
    lane_old = (o >> sh) % m;
    lane_new = longint'(wdata) % m;
    return 32'(o - (lane_old << sh) + (lane_new << sh));
  endfunction

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    @(negedge clk);
    bd_we = 1'b0;
    refmem[idx] = data;
  endtask

  // Issue one request from an IDLE-cycle negedge; returns at the next IDLE negedge.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [5:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er, output int lat);
    logic [3:0]  idx;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_lat, exp_reads, exp_writes, reads, writes;
    logic        got;
    idx        = addr[5:2];
    exp_err    = ref_err(size, addr);
    exp_rd     = (!we && !exp_err) ? ref_load(refmem[idx], size, uns, addr) : 32'h0;
    exp_lat    = exp_err ? 1 : (!we ? 3 : (size == 2'd2 ? 2 : 4));
    exp_reads  = (exp_err || (we && size == 2'd2)) ? 0 : 1;
    exp_writes = (!exp_err && we) ? 1 : 0;
    if (we && !exp_err) refmem[idx] = ref_store(refmem[idx], size, addr, wdata);

    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_idle: addr %h got %b required 1", addr, bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    reads = 0; writes = 0; got = 1'b0; lat = 0; rd = 'x; er = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.memRead === 1'b1) reads++;
      if (bus.memWrite === 1'b1) writes++;
      if (bus.memRead === 1'b1 || bus.memWrite === 1'b1) begin
        n_checks++;
        if (bus.mem_address !== idx) begin
          n_fail++;
          $display("FAIL mem_address: got %0d required %0d", bus.mem_address, idx);
        end
      end
      n_checks++;
      if (bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_busy: cycle %0d got %b required 0", c, bus.req_ready);
      end
      if (bus.resp_valid === 1'b1) begin
        got = 1'b1; lat = c; rd = bus.resp_rdata; er = bus.resp_err;
        break;
      end
      // Garbage on the request lines while busy must be ignored.
      bus.req_valid = 1'($urandom); bus.req_we = 1'($urandom); bus.req_size = 2'($urandom);
      bus.req_unsigned = 1'($urandom); bus.req_addr = 6'($urandom); bus.req_wdata = $urandom;
    end
    bus.req_valid = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL resp_timeout: addr %h no resp_valid within 8 cycles", addr);
    end else begin
      n_checks++;
      if (lat != exp_lat) begin
        n_fail++;
        $display("FAIL latency: addr %h we %b size %0d got %0d required %0d", addr, we, size, lat, exp_lat);
      end
      n_checks++;
      if (er !== exp_err) begin
        n_fail++;
        $display("FAIL resp_err: addr %h size %0d got %b required %b", addr, size, er, exp_err);
      end
      n_checks++;
      if (rd !== exp_rd) begin
        n_fail++;
        $display("FAIL resp_rdata: addr %h size %0d uns %b got %h required %h", addr, size, uns, rd, exp_rd);
      end
    end
    n_checks++;
    if (reads != exp_reads || writes != exp_writes) begin
      n_fail++;
      $display("FAIL strobes: addr %h got rd=%0d wr=%0d required rd=%0d wr=%0d",
               addr, reads, writes, exp_reads, exp_writes);
    end
    @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_pulse: got %b required 0 one cycle after response", bus.resp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 ||
        bus.resp_rdata !== 32'h0 || bus.memRead !== 1'b0 || bus.memWrite !== 1'b0 ||
        bus.mem_data_in !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b rv=%b re=%b rd=%h mr=%b mw=%b di=%h required all 0",
               bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata,
               bus.memRead, bus.memWrite, bus.mem_data_in);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b required 1", bus.req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_loads();
    logic [31:0] rd; logic er; int lat;
    preload(4'd0, 32'h8081_7F01);
    do_req(1'b0, 2'd0, 1'b0, 6'h1, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h0000_007F || er !== 1'b0 || lat != 3) begin
      n_fail++; $display("FAIL lb_0x1: got %h err %b lat %0d required 0000007f 0 3", rd, er, lat);
    end
    do_req(1'b0, 2'd0, 1'b0, 6'h2, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hFFFF_FF81) begin
      n_fail++; $display("FAIL lb_0x2: got %h required ffffff81", rd);
    end
    do_req(1'b0, 2'd0, 1'b1, 6'h2, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h0000_0081 || er !== 1'b0) begin
      n_fail++; $display("FAIL lbu_0x2: got %h err %b required 00000081 0", rd, er);
    end
  endtask

  task automatic test_word_store();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'd2, 1'b0, 6'hC, 32'hDEAD_BEEF, rd, er, lat);
    n_checks++;
    if (lat != 2 || mem[3] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL sw_0xC: lat %0d word3 %h required 2 deadbeef", lat, mem[3]);
    end
    do_req(1'b0, 2'd2, 1'b0, 6'hC, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL lw_0xC: got %h required deadbeef", rd);
    end
  endtask

  task automatic test_rmw();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'd0, 1'b0, 6'hD, 32'h0000_0055, rd, er, lat);
    n_checks++;
    if (mem[3] !== 32'hDEAD_55EF || lat != 4) begin
      n_fail++; $display("FAIL sb_0xD: word3 %h lat %0d required dead55ef 4", mem[3], lat);
    end
    do_req(1'b1, 2'd1, 1'b0, 6'hE, 32'hFFFF_1234, rd, er, lat);
    n_checks++;
    if (mem[3] !== 32'h1234_55EF) begin
      n_fail++; $display("FAIL sh_0xE: word3 %h required 123455ef", mem[3]);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] snap0;
    snap0 = mem[0];
    do_req(1'b0, 2'd2, 1'b0, 6'h2, 32'h0, rd, er, lat);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin
      n_fail++; $display("FAIL lw_0x2_err: err %b rd %h lat %0d required 1 0 1", er, rd, lat);
    end
    do_req(1'b1, 2'd1, 1'b0, 6'h3, 32'h0000_ABCD, rd, er, lat);
    n_checks++;
    if (er !== 1'b1 || lat != 1) begin
      n_fail++; $display("FAIL sh_0x3_err: err %b lat %0d required 1 1", er, lat);
    end
    do_req(1'b1, 2'd3, 1'b0, 6'h0, 32'h1111_2222, rd, er, lat);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0 || mem[0] !== snap0) begin
      n_fail++; $display("FAIL size11_err: err %b rd %h word0 %h required 1 0 %h", er, rd, mem[0], snap0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] snap;
    int wr_seen, rv_seen;
    snap = mem[3];
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 6'hD; bus.req_wdata = 32'hAA;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wr_seen = 0; rv_seen = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (bus.memWrite === 1'b1) wr_seen++;
      if (bus.resp_valid === 1'b1) rv_seen++;
      n_checks++;
      if (bus.req_ready !== 1'b0) begin
        n_fail++; $display("FAIL ready_in_reset: got %b required 0", bus.req_ready);
      end
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_abort: got %b required 1", bus.req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.memWrite === 1'b1) wr_seen++;
      if (bus.resp_valid === 1'b1) rv_seen++;
    end
    n_checks++;
    if (wr_seen != 0 || rv_seen != 0 || mem[3] !== snap) begin
      n_fail++;
      $display("FAIL abort_sb: writes %0d resps %0d word3 %h required 0 0 %h", wr_seen, rv_seen, mem[3], snap);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 12; i++)
      do_req(1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom), 6'($urandom), $urandom, rd, er, lat);
  endtask

  task automatic test_random();
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 6'($urandom), $urandom, rd, er, lat);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (mem[i] !== refmem[i]) begin
        n_fail++; $display("FAIL final_mem[%0d]: got %h required %h", i, mem[i], refmem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 16; i++) preload(4'(i), $urandom);
    test_loads();
    test_word_store();
    test_rmw();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule
